// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM status, arbiter FSM states and the abort fill word.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IREAD  = 2'd1,
    ARB_DREAD  = 2'd2,
    ARB_DWRITE = 2'd3
  } arb_state_t;

  localparam logic [31:0] ARB_BAD_DATA = 32'hBAD1BAD1;

  // True when the requester that owns the current access still holds its request.
  function automatic logic req_held(input arb_state_t st, input logic iren,
                                    input logic dren, input logic dwen);
    logic held;
    case (st)
      ARB_IREAD:  held = iren;
      ARB_DREAD:  held = dren;
      ARB_DWRITE: held = dwen;
      default:    held = 1'b0;
    endcase
    return held;
  endfunction

endpackage

// File: rtl/pipeline_mem_arbiter.sv
// Single-port RAM arbiter: data requests win over instruction fetches; each
// grant is tracked by a small FSM with a saturating timeout counter.
module pipeline_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        mem_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      addr_r, store_r, iload_r, dload_r;
  logic             ihit_r, dhit_r, mem_err_r;
  logic             grant_s, done_s, abort_s, hit_s;
  logic [31:0]      data_s;

  // Next-state: arbitrate in idle (skipping hit cycles), finish or abort in access states.
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    done_s  = 1'b0;
    abort_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (ihit_r || dhit_r) begin
          state_s = ARB_IDLE;
        end else if (dWEN) begin
          state_s = ARB_DWRITE;
          grant_s = 1'b1;
        end else if (dREN) begin
          state_s = ARB_DREAD;
          grant_s = 1'b1;
        end else if (iREN) begin
          state_s = ARB_IREAD;
          grant_s = 1'b1;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      default: begin
        if (ramstate == ACCESS) begin
          done_s  = 1'b1;
          state_s = ARB_IDLE;
        end else if ((ramstate == ERROR) || (cnt_r == CNT_LAST)) begin
          abort_s = 1'b1;
          state_s = ARB_IDLE;
        end else begin
          state_s = state_r;
        end
      end
    endcase
  end

  // A hit is only issued if the owner is still asking when the access ends.
  assign hit_s  = (done_s || abort_s) && req_held(state_r, iREN, dREN, dWEN);
  assign data_s = done_s ? ramload : ARB_BAD_DATA;

  // FSM state, grant latches, timeout counter, hit pulses and load registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= ARB_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      addr_r    <= 32'd0;
      store_r   <= 32'd0;
      ihit_r    <= 1'b0;
      dhit_r    <= 1'b0;
      iload_r   <= 32'd0;
      dload_r   <= 32'd0;
      mem_err_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ihit_r  <= hit_s && (state_r == ARB_IREAD);
      dhit_r  <= hit_s && (state_r != ARB_IREAD);
      if (grant_s) begin
        addr_r  <= (state_s == ARB_IREAD) ? iaddr : daddr;
        store_r <= (state_s == ARB_DWRITE) ? dstore : 32'd0;
        cnt_r   <= {CNT_W{1'b0}};
      end else if ((state_r != ARB_IDLE) && (cnt_r != CNT_LAST)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (abort_s) begin
        mem_err_r <= 1'b1;
      end
      if (hit_s && (state_r == ARB_IREAD)) begin
        iload_r <= data_s;
      end
      if (hit_s && (state_r == ARB_DREAD)) begin
        dload_r <= data_s;
      end
    end
  end

  // Strobes decode straight from the state register so they fall with nRST.
  assign ramREN   = (state_r == ARB_IREAD) || (state_r == ARB_DREAD);
  assign ramWEN   = (state_r == ARB_DWRITE);
  assign ramaddr  = (state_r != ARB_IDLE) ? addr_r : 32'd0;
  assign ramstore = (state_r == ARB_DWRITE) ? store_r : 32'd0;
  assign ihit     = ihit_r;
  assign dhit     = dhit_r;
  assign iload    = iload_r;
  assign dload    = dload_r;
  assign mem_err  = mem_err_r;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter: a vector table of single accesses
// plus hand sequences for contention, hit guard, dropped request and reset.
module tb_pipeline_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = 32'd0, daddr = 32'd0, dstore = 32'd0, ramload = 32'd0;
  ramstate_t   ramstate = FREE;
  logic        ihit, dhit, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int passed = 0;
  int total  = 0;

  pipeline_mem_arbiter #(.TIMEOUT(16)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  // kind: 0 ifetch, 1 data read, 2 data write, 3 read+write (acts as write)
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          busy_n;
    ramstate_t   fin;
    logic [31:0] rload;
    logic [31:0] exp_load;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic wr;
    wr = (v.kind >= 2);
    iREN   = (v.kind == 0);
    dREN   = (v.kind == 1) || (v.kind == 3);
    dWEN   = wr;
    iaddr  = v.addr;
    daddr  = v.addr;
    dstore = v.wdata;
    step();
    for (int i = 0; i <= v.busy_n; i++) begin
      ramstate = (i == v.busy_n) ? v.fin : BUSY;
      ramload  = v.rload;
      chk($sformatf("v%0d c%0d ramREN", idx, i), {31'd0, ramREN}, {31'd0, !wr});
      chk($sformatf("v%0d c%0d ramWEN", idx, i), {31'd0, ramWEN}, {31'd0, wr});
      chk($sformatf("v%0d c%0d ramaddr", idx, i), ramaddr, v.addr);
      chk($sformatf("v%0d c%0d ramstore", idx, i), ramstore, wr ? v.wdata : 32'd0);
      chk($sformatf("v%0d c%0d early hit", idx, i), {30'd0, ihit, dhit}, 32'd0);
      step();
    end
    ramstate = FREE;
    chk($sformatf("v%0d hits", idx), {30'd0, ihit, dhit}, (v.kind == 0) ? 32'd2 : 32'd1);
    chk($sformatf("v%0d load", idx), (v.kind == 0) ? iload : dload, v.exp_load);
    chk($sformatf("v%0d mem_err", idx), {31'd0, mem_err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d strobes idle", idx), {30'd0, ramREN, ramWEN}, 32'd0);
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    step();
    chk($sformatf("v%0d hit drop", idx), {30'd0, ihit, dhit}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, 32'h40,  32'h0,        2,  ACCESS, 32'h8C220004, 32'h8C220004, 1'b0};
    vecs[1] = '{1, 32'h100, 32'h0,        0,  ACCESS, 32'h12345678, 32'h12345678, 1'b0};
    vecs[2] = '{3, 32'h200, 32'hDEADBEEF, 1,  ACCESS, 32'h55555555, 32'h12345678, 1'b0};
    vecs[3] = '{2, 32'h204, 32'hCAFEF00D, 0,  ACCESS, 32'h66666666, 32'h12345678, 1'b0};
    vecs[4] = '{0, 32'h44,  32'h0,        3,  ACCESS, 32'h00000013, 32'h00000013, 1'b0};
    vecs[5] = '{1, 32'h300, 32'h0,        1,  ERROR,  32'h77777777, 32'hBAD1BAD1, 1'b1};
    vecs[6] = '{0, 32'h48,  32'h0,        0,  ERROR,  32'h88888888, 32'hBAD1BAD1, 1'b1};
    vecs[7] = '{1, 32'h400, 32'h0,        15, BUSY,   32'h99999999, 32'hBAD1BAD1, 1'b1};

    #2;
    chk("reset outputs", {ihit, dhit, ramREN, ramWEN, mem_err, 27'd0}, 32'd0);
    chk("reset iload", iload, 32'd0);
    chk("reset dload", dload, 32'd0);
    chk("reset ramaddr", ramaddr, 32'd0);
    step();
    nRST = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Contention: data first, instruction granted right after the dhit guard cycle.
    iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h100;
    step();
    chk("cont d ramaddr", ramaddr, 32'h100);
    chk("cont d ramREN", {31'd0, ramREN}, 32'd1);
    ramstate = ACCESS; ramload = 32'hA5A5A5A5;
    step();
    ramstate = FREE;
    chk("cont dhit only", {30'd0, ihit, dhit}, 32'd1);
    chk("cont dload", dload, 32'hA5A5A5A5);
    dREN = 1'b0;
    step();
    chk("cont guard cycle", {29'd0, ihit, dhit, ramREN}, 32'd0);
    step();
    chk("cont i ramaddr", ramaddr, 32'h40);
    chk("cont i ramREN", {31'd0, ramREN}, 32'd1);
    ramstate = ACCESS; ramload = 32'h0BADF00D;
    step();
    ramstate = FREE;
    chk("cont ihit only", {30'd0, ihit, dhit}, 32'd2);
    chk("cont iload", iload, 32'h0BADF00D);
    iREN = 1'b0;
    step();

    // Hit guard: iREN held through ihit re-grants exactly two cycles later.
    iREN = 1'b1; iaddr = 32'h80;
    step();
    ramstate = ACCESS; ramload = 32'h11111111;
    step();
    ramstate = FREE;
    chk("guard ihit1", {31'd0, ihit}, 32'd1);
    chk("guard iload1", iload, 32'h11111111);
    iaddr = 32'h84;
    step();
    chk("guard +1 idle", {29'd0, ihit, dhit, ramREN}, 32'd0);
    step();
    chk("guard +2 ramREN", {31'd0, ramREN}, 32'd1);
    chk("guard +2 ramaddr", ramaddr, 32'h84);
    chk("guard +2 no hit", {30'd0, ihit, dhit}, 32'd0);
    ramstate = ACCESS; ramload = 32'h22222222;
    step();
    ramstate = FREE;
    iREN = 1'b0;
    chk("guard iload2", iload, 32'h22222222);
    step();
    chk("guard end", {29'd0, ihit, dhit, ramREN}, 32'd0);

    // Dropped request: access completes silently, iload holds.
    iREN = 1'b1; iaddr = 32'h90;
    step();
    chk("drop ramREN", {31'd0, ramREN}, 32'd1);
    iREN = 1'b0; ramstate = BUSY;
    step();
    ramstate = ACCESS; ramload = 32'h33333333;
    step();
    ramstate = FREE;
    chk("drop no hit", {29'd0, ihit, dhit, ramREN}, 32'd0);
    chk("drop iload held", iload, 32'h22222222);
    step();
    chk("drop still idle", {29'd0, ihit, dhit, ramREN}, 32'd0);

    // Reset during a write: strobes drop without waiting for a clock edge.
    dWEN = 1'b1; daddr = 32'h500; dstore = 32'h01020304;
    step();
    chk("rst pre ramWEN", {31'd0, ramWEN}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("rst ctrl outs", {ihit, dhit, ramREN, ramWEN, mem_err, 27'd0}, 32'd0);
    chk("rst ramaddr", ramaddr, 32'd0);
    chk("rst ramstore", ramstore, 32'd0);
    chk("rst loads", iload | dload, 32'd0);
    dWEN = 1'b0;
    step();
    nRST = 1'b1;
    step();

    // Timeout after a clean reset, then mem_err must stay sticky.
    run_vec(8, vecs[7]);
    repeat (100) @(posedge CLK);
    #1;
    chk("mem_err sticky", {31'd0, mem_err}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
